// File: rtl/lsu_if.sv
// Execute-stage request, memory bus and writeback bundle of the load/store unit.
// The lsu uses the slave modport; the surrounding pipeline/memory uses master.
interface lsu_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_is_load_i;
  logic            req_is_store_i;
  logic [2:0]      req_funct3_i;
  logic [XLEN-1:0] req_alu_i;
  logic [XLEN-1:0] req_sdata_i;
  logic [4:0]      req_rd_i;
  logic            req_wen_i;

  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic            mem_req_we_o;
  logic [XLEN-1:0] mem_req_addr_o;
  logic [XLEN-1:0] mem_req_wdata_o;
  logic [3:0]      mem_req_wmask_o;
  logic            mem_rsp_valid_i;
  logic [XLEN-1:0] mem_rsp_rdata_i;
  logic            mem_rsp_err_i;

  logic            wb_valid_o;
  logic            wb_wen_o;
  logic [4:0]      wb_rd_o;
  logic [XLEN-1:0] wb_e_wdata_o;
  logic            wb_is_load_o;
  logic [XLEN-1:0] wb_m_wdata_o;
  logic            err_o;
  logic [XLEN-1:0] err_addr_o;

  modport slave (
    input  req_valid_i, req_is_load_i, req_is_store_i, req_funct3_i,
           req_alu_i, req_sdata_i, req_rd_i, req_wen_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_err_i,
    output req_ready_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o,
           mem_req_wdata_o, mem_req_wmask_o, wb_valid_o, wb_wen_o, wb_rd_o,
           wb_e_wdata_o, wb_is_load_o, wb_m_wdata_o, err_o, err_addr_o
  );

  modport master (
    output req_valid_i, req_is_load_i, req_is_store_i, req_funct3_i,
           req_alu_i, req_sdata_i, req_rd_i, req_wen_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_err_i,
    input  req_ready_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o,
           mem_req_wdata_o, mem_req_wmask_o, wb_valid_o, wb_wen_o, wb_rd_o,
           wb_e_wdata_o, wb_is_load_o, wb_m_wdata_o, err_o, err_addr_o
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one instruction at a time, at most one memory access,
// one-cycle registered writeback bundle or error strobe.
module lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic  clk_i,
  input  logic  rst_i,
  lsu_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, RSP, WB} state_t;

  state_t          r_state, w_next;
  logic            w_accept, w_is_mem, w_f3_ok, w_align_ok, w_legal;
  logic [XLEN-1:0] w_wdata, w_ldata;
  logic [3:0]      w_wmask;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  logic            r_is_load, r_wen;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_alu;
  logic            r_mem_valid, r_mem_we;
  logic [XLEN-1:0] r_mem_addr, r_mem_wdata;
  logic [3:0]      r_mem_wmask;
  logic            r_wb_valid, r_wb_wen, r_wb_is_load, r_err;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_e, r_wb_m, r_err_addr;

  assign bus.req_ready_o = (r_state == IDLE) && !rst_i;
  assign w_accept        = bus.req_valid_i && bus.req_ready_o;
  assign w_is_mem        = bus.req_is_load_i || bus.req_is_store_i;
  assign w_legal         = w_f3_ok && w_align_ok;

  always_comb begin
    w_f3_ok    = 1'b0;
    w_align_ok = 1'b1;
    if (bus.req_is_load_i && !bus.req_is_store_i)
      w_f3_ok = bus.req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (bus.req_is_store_i && !bus.req_is_load_i)
      w_f3_ok = bus.req_funct3_i inside {3'b000, 3'b001, 3'b010};
    case (bus.req_funct3_i[1:0])
      2'b01:   w_align_ok = !bus.req_alu_i[0];
      2'b10:   w_align_ok = (bus.req_alu_i[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
  end

  always_comb begin
    w_wdata = bus.req_sdata_i;
    w_wmask = 4'b1111;
    case (bus.req_funct3_i[1:0])
      2'b00: begin
        w_wdata = {4{bus.req_sdata_i[7:0]}};
        w_wmask = 4'b0001 << bus.req_alu_i[1:0];
      end
      2'b01: begin
        w_wdata = {2{bus.req_sdata_i[15:0]}};
        w_wmask = 4'b0011 << bus.req_alu_i[1:0];
      end
      default: ;
    endcase
  end

  // Halfword loads are known aligned, so only addr[1] selects the half.
  assign w_byte = bus.mem_rsp_rdata_i[{r_alu[1:0], 3'b000} +: 8];
  assign w_half = bus.mem_rsp_rdata_i[{r_alu[1], 4'b0000} +: 16];

  always_comb begin
    w_ldata = bus.mem_rsp_rdata_i;
    case (r_funct3)
      3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
      3'b100:  w_ldata = {24'b0, w_byte};
      3'b101:  w_ldata = {16'b0, w_half};
      default: w_ldata = bus.mem_rsp_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (w_is_mem && w_legal) ? REQ : WB;
      REQ:     if (bus.mem_req_ready_i) w_next = RSP;
      RSP:     if (bus.mem_rsp_valid_i) w_next = WB;
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Writeback/error registers default to 0 every cycle and are loaded only on
  // entry to WB, which makes them a one-cycle pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_is_load <= 1'b0;  r_wen <= 1'b0;  r_rd <= '0;  r_funct3 <= '0;  r_alu <= '0;
      r_mem_valid <= 1'b0;  r_mem_we <= 1'b0;  r_mem_addr <= '0;
      r_mem_wdata <= '0;  r_mem_wmask <= '0;
      r_wb_valid <= 1'b0;  r_wb_wen <= 1'b0;  r_wb_is_load <= 1'b0;  r_err <= 1'b0;
      r_wb_rd <= '0;  r_wb_e <= '0;  r_wb_m <= '0;  r_err_addr <= '0;
    end else begin
      r_wb_valid <= 1'b0;  r_wb_wen <= 1'b0;  r_wb_is_load <= 1'b0;  r_err <= 1'b0;
      r_wb_rd <= '0;  r_wb_e <= '0;  r_wb_m <= '0;  r_err_addr <= '0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_is_load <= bus.req_is_load_i;
          r_wen     <= bus.req_wen_i;
          r_rd      <= bus.req_rd_i;
          r_funct3  <= bus.req_funct3_i;
          r_alu     <= bus.req_alu_i;
          if (!w_is_mem) begin
            r_wb_valid <= 1'b1;
            r_wb_wen   <= bus.req_wen_i;
            r_wb_rd    <= bus.req_rd_i;
            r_wb_e     <= bus.req_alu_i;
          end else if (!w_legal) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= bus.req_rd_i;
            r_wb_e     <= bus.req_alu_i;
            r_err      <= 1'b1;
            r_err_addr <= bus.req_alu_i;
          end else begin
            r_mem_valid <= 1'b1;
            r_mem_we    <= bus.req_is_store_i;
            r_mem_addr  <= {bus.req_alu_i[XLEN-1:2], 2'b00};
            r_mem_wdata <= w_wdata;
            r_mem_wmask <= w_wmask;
          end
        end
        REQ: if (bus.mem_req_ready_i) r_mem_valid <= 1'b0;
        RSP: if (bus.mem_rsp_valid_i) begin
          r_wb_valid <= 1'b1;
          r_wb_rd    <= r_rd;
          r_wb_e     <= r_alu;
          if (bus.mem_rsp_err_i) begin
            r_err      <= 1'b1;
            r_err_addr <= r_alu;
          end else begin
            r_wb_wen     <= r_wen && r_is_load;
            r_wb_is_load <= r_is_load;
            r_wb_m       <= r_is_load ? w_ldata : '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req_valid_o = r_mem_valid;
  assign bus.mem_req_we_o    = r_mem_we;
  assign bus.mem_req_addr_o  = r_mem_addr;
  assign bus.mem_req_wdata_o = r_mem_wdata;
  assign bus.mem_req_wmask_o = r_mem_wmask;
  assign bus.wb_valid_o      = r_wb_valid;
  assign bus.wb_wen_o        = r_wb_wen;
  assign bus.wb_rd_o         = r_wb_rd;
  assign bus.wb_e_wdata_o    = r_wb_e;
  assign bus.wb_is_load_o    = r_wb_is_load;
  assign bus.wb_m_wdata_o    = r_wb_m;
  assign bus.err_o           = r_err;
  assign bus.err_addr_o      = r_err_addr;
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: transaction-level expected bundle, cycle schedule derived from
// the documented latencies, per-cycle compare on the falling edge.
module tb_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if #(.XLEN(32)) bus ();
  lsu #(.XLEN(32)) u_dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  typedef struct packed {
    logic        mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] e;
    logic [31:0] m;
    logic        is_load;
    logic        err;
    logic [31:0] err_addr;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;
  logic exp_ready = 1'b0, exp_mv = 1'b0, exp_wv = 1'b0;
  exp_t cur = '0;
  logic [2:0] ldf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected outcome of one instruction, straight from the width/lane rules.
  function automatic exp_t model(logic ld, logic st, logic [2:0] f3, logic [31:0] alu,
                                 logic [31:0] sd, logic [4:0] rd, logic wen,
                                 logic [31:0] rdata, logic rerr);
    exp_t        e;
    int unsigned a, sz;
    logic [31:0] v;
    bit          illegal;
    e = '0;
    e.rd = rd;
    e.e  = alu;
    a  = alu % 4;
    sz = 1 << f3[1:0];
    if (!ld && !st) begin
      e.wen = wen;
      return e;
    end
    illegal = (ld && st)
           || (ld && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5))
           || (st && !(f3 <= 2))
           || (alu % sz != 0);
    if (illegal) begin
      e.err = 1'b1;
      e.err_addr = alu;
      return e;
    end
    e.mem  = 1'b1;
    e.we   = st;
    e.addr = alu - a;
    if (st) begin
      if (sz == 1)      begin e.wdata = 32'(sd[7:0]) * 32'h01010101;  e.wmask = 4'(1 << a); end
      else if (sz == 2) begin e.wdata = 32'(sd[15:0]) * 32'h00010001; e.wmask = 4'(3 << a); end
      else              begin e.wdata = sd;                           e.wmask = 4'hF;      end
    end
    if (rerr) begin
      e.err = 1'b1;
      e.err_addr = alu;
      return e;
    end
    if (ld) begin
      e.wen = wen;
      e.is_load = 1'b1;
      v = rdata >> (8 * a);
      if (sz == 1) begin
        v = v & 32'hFF;
        if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
      end else if (sz == 2) begin
        v = v & 32'hFFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
      end
      e.m = v;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(bus.req_ready_o), 32'(exp_ready));
      chk("mem_req_valid", 32'(bus.mem_req_valid_o), 32'(exp_mv));
      if (exp_mv) begin
        chk("mem_req_addr", bus.mem_req_addr_o, cur.addr);
        chk("mem_req_we", 32'(bus.mem_req_we_o), 32'(cur.we));
        if (cur.we) begin
          chk("mem_req_wdata", bus.mem_req_wdata_o, cur.wdata);
          chk("mem_req_wmask", 32'(bus.mem_req_wmask_o), 32'(cur.wmask));
        end
      end
      chk("wb_valid", 32'(bus.wb_valid_o), 32'(exp_wv));
      chk("err", 32'(bus.err_o), 32'(exp_wv && cur.err));
      if (exp_wv) begin
        chk("wb_wen", 32'(bus.wb_wen_o), 32'(cur.wen));
        chk("wb_rd", 32'(bus.wb_rd_o), 32'(cur.rd));
        chk("wb_e_wdata", bus.wb_e_wdata_o, cur.e);
        chk("wb_is_load", 32'(bus.wb_is_load_o), 32'(cur.is_load));
        chk("wb_m_wdata", bus.wb_m_wdata_o, cur.m);
        if (cur.err) chk("err_addr", bus.err_addr_o, cur.err_addr);
      end
    end
  end

  task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                         input logic wen, input int unsigned d1, input int unsigned d2,
                         input logic [31:0] rdata, input logic rerr, input exp_t e);
    @(posedge clk); #1;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_err_i   = 1'b0;
    bus.req_valid_i = 1'b1;  bus.req_is_load_i = ld;  bus.req_is_store_i = st;
    bus.req_funct3_i = f3;   bus.req_alu_i = alu;     bus.req_sdata_i = sd;
    bus.req_rd_i = rd;       bus.req_wen_i = wen;
    cur = e;  exp_ready = 1'b1;  exp_mv = 1'b0;  exp_wv = 1'b0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.req_alu_i = $urandom;  bus.req_sdata_i = $urandom;  bus.req_funct3_i = 3'($urandom);
    bus.req_rd_i = 5'($urandom);  bus.req_wen_i = 1'($urandom);
    exp_ready = 1'b0;
    if (!e.mem) begin
      exp_wv = 1'b1;
    end else begin
      exp_mv = 1'b1;
      for (int unsigned i = 0; i < d1; i++) begin
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rsp_valid_i = 1'($urandom);
        bus.mem_rsp_err_i   = 1'($urandom);
        bus.mem_rsp_rdata_i = $urandom;
        @(posedge clk); #1;
      end
      bus.mem_req_ready_i = 1'b1;
      bus.mem_rsp_valid_i = 1'($urandom);
      bus.mem_rsp_err_i   = 1'($urandom);
      @(posedge clk); #1;
      bus.mem_req_ready_i = 1'b0;
      bus.mem_rsp_valid_i = 1'b0;
      exp_mv = 1'b0;
      for (int unsigned i = 0; i < d2; i++) begin
        bus.mem_rsp_rdata_i = $urandom;
        @(posedge clk); #1;
      end
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_rdata_i = rdata;
      bus.mem_rsp_err_i   = rerr;
      @(posedge clk); #1;
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rsp_err_i   = 1'b0;
      bus.mem_rsp_rdata_i = $urandom;
      exp_wv = 1'b1;
    end
    @(posedge clk); #1;
    exp_wv = 1'b0;  exp_ready = 1'b1;
    bus.mem_rsp_valid_i = 1'($urandom);
    bus.mem_rsp_err_i   = 1'($urandom);
  endtask

  // Abandon a word load by asserting reset mid-cycle in REQ or RSP.
  task automatic reset_mid(input bit in_req);
    @(posedge clk); #1;
    bus.mem_rsp_valid_i = 1'b0;  bus.mem_rsp_err_i = 1'b0;
    bus.req_valid_i = 1'b1;  bus.req_is_load_i = 1'b1;  bus.req_is_store_i = 1'b0;
    bus.req_funct3_i = 3'd2;  bus.req_alu_i = 32'h0000_0100;  bus.req_rd_i = 5'd4;
    bus.req_wen_i = 1'b1;
    cur = model(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 5'd4, 1'b1, 32'h0, 1'b0);
    exp_ready = 1'b1;  exp_mv = 1'b0;  exp_wv = 1'b0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;  exp_ready = 1'b0;  exp_mv = 1'b1;
    bus.mem_req_ready_i = !in_req;
    @(posedge clk); #1;
    bus.mem_req_ready_i = 1'b0;
    if (!in_req) exp_mv = 1'b0;
    #1;
    rst = 1'b1;  exp_ready = 1'b0;  exp_mv = 1'b0;
    #1;
    chk("rst_async_req_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_async_mem_req_valid", 32'(bus.mem_req_valid_o), 32'd0);
    chk("rst_async_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("rst_async_err", 32'(bus.err_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;  exp_ready = 1'b1;
    bus.mem_rsp_valid_i = 1'b1;  bus.mem_rsp_rdata_i = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.mem_rsp_valid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin : main
    exp_t        e;
    logic        ld, st, wen, rerr;
    logic [2:0]  f3;
    logic [31:0] alu, sd, rdata;
    logic [4:0]  rd;
    int unsigned kind;

    bus.req_valid_i = 1'b0;  bus.req_is_load_i = 1'b0;  bus.req_is_store_i = 1'b0;
    bus.req_funct3_i = '0;   bus.req_alu_i = '0;        bus.req_sdata_i = '0;
    bus.req_rd_i = '0;       bus.req_wen_i = 1'b0;
    bus.mem_req_ready_i = 1'b0;  bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_rdata_i = '0;    bus.mem_rsp_err_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(bus.req_ready_o), 32'd0);
    chk("reset_mem_req_valid", 32'(bus.mem_req_valid_o), 32'd0);
    chk("reset_mem_req_we", 32'(bus.mem_req_we_o), 32'd0);
    chk("reset_mem_req_addr", bus.mem_req_addr_o, 32'd0);
    chk("reset_mem_req_wdata", bus.mem_req_wdata_o, 32'd0);
    chk("reset_mem_req_wmask", 32'(bus.mem_req_wmask_o), 32'd0);
    chk("reset_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("reset_wb_wen", 32'(bus.wb_wen_o), 32'd0);
    chk("reset_wb_rd", 32'(bus.wb_rd_o), 32'd0);
    chk("reset_wb_e_wdata", bus.wb_e_wdata_o, 32'd0);
    chk("reset_wb_is_load", 32'(bus.wb_is_load_o), 32'd0);
    chk("reset_wb_m_wdata", bus.wb_m_wdata_o, 32'd0);
    chk("reset_err", 32'(bus.err_o), 32'd0);
    chk("reset_err_addr", bus.err_addr_o, 32'd0);
    rst = 1'b0;
    exp_ready = 1'b1;
    chk_en = 1'b1;

    e = '0;  e.wen = 1'b1;  e.rd = 5'd5;  e.e = 32'h1234;
    run_txn(1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0, 1'b0, e);

    e = '0;  e.mem = 1'b1;  e.addr = 32'h8000_0000;  e.wen = 1'b1;  e.rd = 5'd7;
    e.e = 32'h8000_0003;  e.is_load = 1'b1;  e.m = 32'hFFFF_FF8F;
    run_txn(1'b1, 1'b0, 3'd0, 32'h8000_0003, 32'h0, 5'd7, 1'b1, 0, 0, 32'h8F00_0000, 1'b0, e);
    e.m = 32'h0000_008F;
    run_txn(1'b1, 1'b0, 3'd4, 32'h8000_0003, 32'h0, 5'd7, 1'b1, 0, 0, 32'h8F00_0000, 1'b0, e);

    e = '0;  e.mem = 1'b1;  e.we = 1'b1;  e.addr = 32'h8000_0000;  e.wdata = 32'hBEEF_BEEF;
    e.wmask = 4'b1100;  e.rd = 5'd3;  e.e = 32'h8000_0002;
    run_txn(1'b0, 1'b1, 3'd1, 32'h8000_0002, 32'hDEAD_BEEF, 5'd3, 1'b1, 3, 0, 32'h0, 1'b0, e);

    e = '0;  e.err = 1'b1;  e.err_addr = 32'h8000_0006;  e.rd = 5'd9;  e.e = 32'h8000_0006;
    run_txn(1'b1, 1'b0, 3'd2, 32'h8000_0006, 32'h0, 5'd9, 1'b1, 0, 0, 32'h0, 1'b0, e);

    e = '0;  e.mem = 1'b1;  e.addr = 32'h8000_0010;  e.err = 1'b1;  e.err_addr = 32'h8000_0010;
    e.rd = 5'd11;  e.e = 32'h8000_0010;
    run_txn(1'b1, 1'b0, 3'd2, 32'h8000_0010, 32'h0, 5'd11, 1'b1, 1, 2, 32'h1234_5678, 1'b1, e);

    reset_mid(1'b0);
    reset_mid(1'b1);

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 7);
      ld = (kind >= 2 && kind <= 4) || kind == 7;
      st = (kind == 5 || kind == 6) || kind == 7;
      if ($urandom_range(0, 5) == 0) f3 = 3'($urandom);
      else if (st)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = ldf[$urandom_range(0, 4)];
      alu = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (f3[1:0] == 2'b01) alu[0] = 1'b0;
        if (f3[1:0] == 2'b10) alu[1:0] = 2'b00;
      end
      sd    = $urandom;
      rd    = 5'($urandom);
      wen   = 1'($urandom);
      rdata = $urandom;
      rerr  = ($urandom_range(0, 7) == 0);
      e = model(ld, st, f3, alu, sd, rd, wen, rdata, rerr);
      run_txn(ld, st, f3, alu, sd, rd, wen, $urandom_range(0, 3), $urandom_range(0, 3),
              rdata, rerr, e);
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the stage directly upstream of the general-purpose register file write port. It accepts one instruction at a time from the execute stage, performs at most one memory access over a simple request/response bus, and presents a one-cycle writeback bundle (write enable, destination, execute result, load flag, aligned and extended load data) that the register file commits on the next rising edge. Misaligned accesses, illegal width encodings and bus errors are reported on a one-cycle error strobe instead of writing back.

## Interface
- XLEN, 32, data and address width; only 32 is supported.
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  execute stage presents an instruction.
- req_ready_o  out  1  lsu accepts; `(state==IDLE) && !rst_i`.
- req_is_load_i / req_is_store_i  in  1 each  memory op kind; both 0 means pass-through; both 1 is illegal and takes the error path.
- req_funct3_i  in  3  RISC-V width/sign encoding.
- req_alu_i  in  XLEN  execute result; used as the effective address for memory ops.
- req_sdata_i  in  XLEN  store data (rs2 value).
- req_rd_i  in  5  destination register; req_wen_i  in  1  instruction writes rd.
- mem_req_valid_o  out  1; mem_req_ready_i  in  1  request handshake.
- mem_req_we_o  out  1; mem_req_addr_o  out  XLEN  word-aligned (`[1:0]=0`); mem_req_wdata_o  out  XLEN; mem_req_wmask_o  out  4.
- mem_rsp_valid_i  in  1; mem_rsp_rdata_i  in  XLEN; mem_rsp_err_i  in  1  response (no backpressure).
- wb_valid_o  out  1  writeback bundle valid, one-cycle pulse.
- wb_wen_o  out  1; wb_rd_o  out  5; wb_e_wdata_o  out  XLEN; wb_is_load_o  out  1; wb_m_wdata_o  out  XLEN.
- err_o  out  1  one-cycle error pulse, coincident with wb_valid_o; err_addr_o  out  XLEN  faulting address.

## Operation
- States: IDLE, REQ, RSP, WB. Reset: IDLE; every registered output 0.
- IDLE: on `req_valid_i && req_ready_o`, latch all req fields.
  - Pass-through: go to WB.
  - Legality check failed: go to WB with error.
  - Otherwise: go to REQ.
- Legality: loads accept funct3 000,001,010,100,101; stores accept 000,001,010. Halfword requires `addr[0]==0`; word requires `addr[1:0]==0`.
- REQ: mem_req_valid_o=1, with addr, we, wdata and wmask held stable. On mem_req_ready_i, go to RSP.
- RSP: wait for mem_rsp_valid_i, then go to WB. A response is sampled only in RSP; one arriving in any other state is ignored.
- WB: wb_valid_o=1 for exactly one cycle, then IDLE.
  - wb_wen_o = latched wen, forced 0 for stores and on any error.
  - wb_is_load_o = 1 for a successful load.
  - wb_e_wdata_o = latched req_alu_i.
  - wb_m_wdata_o = extended load data, 0 otherwise.
- Store data, by lane `a = addr[1:0]`:
  - SB: wdata = `{4{sdata[7:0]}}`, wmask = `4'b0001 << a`.
  - SH: wdata = `{2{sdata[15:0]}}`, wmask = `4'b0011 << a`.
  - SW: wdata = sdata, wmask = 4'b1111.
- Load data: select byte `rdata[8a+7:8a]` or halfword `rdata[8a+15:8a]`. LB/LH sign-extend; LBU/LHU zero-extend; LW uses rdata as is.
- Errors: legality failure or mem_rsp_err_i sets err_o=1 and err_addr_o = latched address, with wb_wen_o=0. Illegal requests never assert mem_req_valid_o.
- rd=0 is passed through unchanged; the register file drops it.
- Reset asserted mid-operation: return to IDLE immediately (asynchronous). mem_req_valid_o, wb_valid_o and err_o drop without waiting for a clock edge. The pending transaction is abandoned; its late response is ignored.

## Timing
- Accept on edge T.
  - Pass-through or illegal: wb_valid_o high during cycle T+1.
  - Memory op: mem_req_valid_o is registered and rises in cycle T+1.
- Zero-wait memory: ready in T+1 and response in T+2 gives wb_valid_o in T+3. Each wait cycle on ready or response adds one cycle.
- Throughput: one instruction per (latency+1) cycles, since req_ready_o=0 in REQ, RSP and WB.
- All wb_* and err_* outputs are registered and valid for the whole WB cycle. The register file commits at the edge ending WB.
- The memory must hold mem_rsp_rdata_i valid only in the mem_rsp_valid_i cycle; the lsu captures it at that edge.

## Test plan
- Pass-through: alu=0x1234, rd=5, wen=1 -> cycle T+1: wb_valid=1, wb_wen=1, wb_rd=5, wb_e_wdata=0x1234, wb_is_load=0; no mem_req_valid.
- LB/LBU at addr 0x80000003, rdata=0x8F000000 -> wb_m_wdata=0xFFFFFF8F (LB) / 0x0000008F (LBU); mem_req_addr=0x80000000; wb_valid in T+3 with zero-wait memory.
- SH at 0x80000002, sdata=0xDEADBEEF -> wdata=0xBEEFBEEF, wmask=4'b1100, we=1; wb_wen=0. Hold ready low 3 cycles -> request fields stable throughout; wb delayed by 3 cycles.
- LW at 0x80000006 -> no mem request; err_o=1, err_addr=0x80000006, wb_wen=0 in T+1.
- LW with mem_rsp_err_i=1 -> err_o=1, wb_wen=0, wb_is_load=0.
- Assert rst_i during RSP, then deliver the response after release -> outputs 0 asynchronously, no wb_valid, req_ready returns to 1, stale response ignored.
